// File: rtl/game_flow_ctrl.sv
// ============================================================================
// Module   : game_flow_ctrl
// Brief    : Rhythm-game flow FSM: song menu, play/pause, per-song best scores
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module game_flow_ctrl #(
    parameter int NUM_SONGS    = 3,
    parameter int NUM_LANES    = 2,
    parameter int SCORE_W      = 16,
    parameter int IDLE_TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 nav_prev_btn,
    input  logic                 nav_next_btn,
    input  logic                 confirm_btn,
    input  logic                 pause_btn,
    input  logic [NUM_LANES-1:0] lane_btn,
    input  logic                 song_finish,
    input  logic [SCORE_W-1:0]   score,
    output logic [2:0]           state,
    output logic [3:0]           song_sel,
    output logic                 song_start,
    output logic                 play_en,
    output logic [NUM_LANES-1:0] lane_press,
    output logic [SCORE_W-1:0]   best_score,
    output logic                 new_best
);

    localparam logic [2:0] ST_START  = 3'd0;
    localparam logic [2:0] ST_MENU   = 3'd1;
    localparam logic [2:0] ST_PLAY   = 3'd2;
    localparam logic [2:0] ST_PAUSE  = 3'd3;
    localparam logic [2:0] ST_FINISH = 3'd4;

    localparam int               CNT_W    = $clog2(IDLE_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IDLE_TIMEOUT - 1);
    localparam logic [3:0]       SEL_MAX  = 4'(NUM_SONGS);

    logic [2:0]           state_q, state_d;
    logic [3:0]           sel_q, sel_d;
    logic                 start_q, start_d;
    logic                 new_best_q, new_best_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [3:0]           btn_q, btn_d;
    logic [NUM_LANES-1:0] lane_q, lane_d;
    logic                 armed_q;
    logic [SCORE_W-1:0]   best_q [NUM_SONGS];
    logic [SCORE_W-1:0]   best_d [NUM_SONGS];

    logic [3:0]           btn_press;
    logic [NUM_LANES-1:0] lane_rise;
    logic                 prev_p, next_p, conf_p, pause_p;
    logic [SCORE_W-1:0]   cur_best;
    logic                 run_end;

    // armed_q masks the first cycle after reset so a button held through release is not a press
    always_comb begin
        btn_d     = {pause_btn, confirm_btn, nav_next_btn, nav_prev_btn};
        lane_d    = lane_btn;
        btn_press = btn_d & ~btn_q & {4{armed_q}};
        lane_rise = lane_btn & ~lane_q & {NUM_LANES{armed_q}};
        prev_p    = btn_press[0];
        next_p    = btn_press[1];
        conf_p    = btn_press[2];
        pause_p   = btn_press[3];
    end

    always_comb begin
        cur_best = '0;
        for (int i = 0; i < NUM_SONGS; i++) begin
            if (sel_q == 4'(i + 1)) cur_best = best_q[i];
        end
    end

    assign run_end = (state_q == ST_PLAY) && song_finish;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_START;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_START:  if (prev_p || next_p || conf_p) state_d = ST_MENU;
            ST_MENU:   if (conf_p && (sel_q != 4'd0)) state_d = ST_PLAY;
            ST_PLAY: begin
                if (song_finish)  state_d = ST_FINISH;
                else if (pause_p) state_d = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (pause_p || conf_p) state_d = ST_PLAY;
                else if (prev_p)       state_d = ST_MENU;
            end
            ST_FINISH: if (conf_p || (cnt_q == CNT_LAST)) state_d = ST_MENU;
            default:   state_d = ST_START;
        endcase
    end

    // Datapath next values
    always_comb begin
        sel_d = sel_q;
        if ((state_q == ST_MENU) && (next_p != prev_p)) begin
            if (next_p) sel_d = (sel_q == SEL_MAX) ? 4'd1 : sel_q + 4'd1;
            else        sel_d = (sel_q <= 4'd1) ? SEL_MAX : sel_q - 4'd1;
        end

        start_d = (state_q == ST_MENU) && (state_d == ST_PLAY);

        new_best_d = new_best_q;
        if (run_end)                   new_best_d = (score > cur_best);
        else if (state_d != ST_FINISH) new_best_d = 1'b0;

        cnt_d = ((state_q == ST_FINISH) && (state_d == ST_FINISH)) ? cnt_q + CNT_W'(1) : '0;

        for (int i = 0; i < NUM_SONGS; i++) begin
            best_d[i] = best_q[i];
            if (run_end && (score > cur_best) && (sel_q == 4'(i + 1))) best_d[i] = score;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_q      <= 4'd0;
            start_q    <= 1'b0;
            new_best_q <= 1'b0;
            cnt_q      <= '0;
            btn_q      <= 4'd0;
            lane_q     <= '0;
            armed_q    <= 1'b0;
            for (int i = 0; i < NUM_SONGS; i++) best_q[i] <= '0;
        end else begin
            sel_q      <= sel_d;
            start_q    <= start_d;
            new_best_q <= new_best_d;
            cnt_q      <= cnt_d;
            btn_q      <= btn_d;
            lane_q     <= lane_d;
            armed_q    <= 1'b1;
            for (int i = 0; i < NUM_SONGS; i++) best_q[i] <= best_d[i];
        end
    end

    // Output logic
    always_comb begin
        state      = state_q;
        song_sel   = sel_q;
        song_start = start_q;
        play_en    = (state_q == ST_PLAY);
        lane_press = play_en ? lane_rise : '0;
        best_score = cur_best;
        new_best   = new_best_q;
    end

endmodule

`default_nettype wire

// File: doc/game_flow_ctrl.md
GAME_FLOW_CTRL -- requirements
Module: game_flow_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_SONGS, default 3, number of selectable songs (legal range 1..15).
REQ-002 The block SHALL have parameter NUM_LANES, default 2, number of note-lane buttons.
REQ-003 The block SHALL have parameter SCORE_W, default 16, score width in bits.
REQ-004 The block SHALL have parameter IDLE_TIMEOUT, default 1024, FINISH auto-return time in clk cycles (legal value ≥2).
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit; reset is asynchronous and active-low.
REQ-007 The block SHALL have ports nav_prev_btn, nav_next_btn, confirm_btn and pause_btn, each input, 1 bit, level button inputs already synchronous to clk.
REQ-008 The block SHALL have port lane_btn, input, NUM_LANES bits, lane button levels.
REQ-009 The block SHALL have port song_finish, input, 1 bit, end-of-chart pulse from the chart player.
REQ-010 The block SHALL have port score, input, SCORE_W bits, current run score from the score counter.
REQ-011 The block SHALL have port state, output, 3 bits, encoded START=0, MENU=1, PLAY=2, PAUSE=3, FINISH=4.
REQ-012 The block SHALL have port song_sel, output, 4 bits, selected song; 0 means none selected.
REQ-013 The block SHALL have port song_start, output, 1 bit, one-cycle chart-load pulse.
REQ-014 The block SHALL have port play_en, output, 1 bit, high iff state==PLAY.
REQ-015 The block SHALL have port lane_press, output, NUM_LANES bits, per-lane rising-edge pulses.
REQ-016 The block SHALL have port best_score, output, SCORE_W bits, stored best score of song_sel.
REQ-017 The block SHALL have port new_best, output, 1 bit, high while in FINISH if the last run set a record.

Function
REQ-018 Every button input SHALL be registered once; a press is defined as current=1 and previous=0, so each held button yields exactly one press.
REQ-019 lane_press[i] SHALL equal the lane i press gated by play_en; it is zero outside PLAY.
REQ-020 The FSM SHALL transition START->MENU on any nav_prev, nav_next or confirm press.
REQ-021 MENU->PLAY SHALL occur on a confirm press only when song_sel!=0; a confirm press with song_sel==0 SHALL be ignored.
REQ-022 song_start SHALL be high for exactly the first cycle in which state==PLAY after MENU, and SHALL NOT pulse on PAUSE->PLAY.
REQ-023 In MENU, a next press SHALL set song_sel to 0->1, k->k+1 and NUM_SONGS->1 (wrap); a prev press SHALL set 0->NUM_SONGS, 1->NUM_SONGS and k->k-1; simultaneous prev and next presses SHALL leave song_sel unchanged; song_sel is frozen outside MENU.
REQ-024 PLAY->FINISH SHALL occur on song_finish=1; PLAY->PAUSE SHALL occur on a pause press; if both occur in the same cycle, FINISH wins.
REQ-025 PAUSE->PLAY SHALL occur on a pause or confirm press; PAUSE->MENU (abort) SHALL occur on a nav_prev press; abort leaves the best table untouched; song_finish is ignored in PAUSE.
REQ-026 On the PLAY->FINISH transition edge, if score > best[song_sel] (unsigned), best[song_sel] SHALL be loaded with score and new_best set; otherwise new_best SHALL be cleared; new_best is held through FINISH and cleared on leaving it.
REQ-027 Best table: NUM_SONGS entries of SCORE_W bits; best_score SHALL equal best[song_sel], or 0 when song_sel==0, with no added latency relative to song_sel.
REQ-028 In FINISH, a cycle counter SHALL start at 0 on entry; FINISH->MENU SHALL occur on a confirm press or when the counter reaches IDLE_TIMEOUT-1, whichever comes first; the counter is held at 0 outside FINISH.
REQ-029 Undefined state encodings (5..7) SHALL return to START on the next clk.

Reset
REQ-030 While rst=0, asynchronously: state=START, song_sel=0, song_start=0, play_en=0, lane_press=0, new_best=0, all best entries=0, button history=0, FINISH counter=0.
REQ-031 Reset asserted mid-PLAY SHALL abort the run without a best update; a button held through reset release SHALL NOT generate a press.

Verification
REQ-032 Scenario: reset, next press, next press, confirm press (defaults) -> state START->MENU, song_sel=1 after the second press, PLAY with song_start a single 1-cycle pulse.
REQ-033 Scenario: in MENU with song_sel=0, prev press -> song_sel=3; next press -> 1; prev and next together -> unchanged; confirm press at song_sel=0 -> stays MENU.
REQ-034 Scenario: in PLAY, score=500, song_finish -> FINISH, best[sel]=500, new_best=1; a second run with score=400 -> best stays 500, new_best=0.
REQ-035 Scenario: PLAY, pause press -> PAUSE, play_en=0, lane_press=0 despite lane presses; pause press -> PLAY with no song_start; pause then nav_prev press -> MENU, best unchanged.
REQ-036 Scenario: FINISH with no input -> MENU exactly IDLE_TIMEOUT cycles after entry; confirm press at cycle 5 -> MENU next cycle.
REQ-037 Scenario: held lane_btn[1] for 10 cycles in PLAY -> exactly one lane_press[1] pulse; reset asserted mid-PLAY -> all outputs at REQ-030 values immediately.
